// File: rtl/serial_add_sub_ctrl.sv
// serial_add_sub_ctrl: wide add/subtract sequenced over a single 4-bit slice.
// Operands are latched on an accepted start. One nibble is processed per clock,
// LSB first, and the carry is chained between nibbles. A one-cycle done pulse
// marks a valid result together with the carry-out, signed overflow and zero flags.
module serial_add_sub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   v,
    output logic                   zero
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic              op_q;
    logic              carry_q;
    logic [W-1:0]      result_q;
    logic              cout_q;
    logic              v_q;
    logic              zero_q;

    logic [31:0]       nib_base_s;
    logic [3:0]        nib_a_s;
    logic [3:0]        nib_bx_s;
    logic [4:0]        sum_s;
    logic              carry_into_b3_s;
    logic              last_s;
    logic [W-1:0]      result_d;

    // Nibble slice: selected operand nibbles, add/sub and the result with this nibble merged in.
    always_comb begin
        nib_base_s      = 32'(idx_q) * 32'd4;
        nib_a_s         = a_q[nib_base_s +: 4];
        // Subtraction is A + ~B + 1; the +1 comes from the carry seeded with op.
        nib_bx_s        = b_q[nib_base_s +: 4] ^ {4{op_q}};
        sum_s           = {1'b0, nib_a_s} + {1'b0, nib_bx_s} + {4'b0000, carry_q};
        // The sum bit is a ^ b ^ carry-in, so the carry into bit 3 falls out of it.
        carry_into_b3_s = nib_a_s[3] ^ nib_bx_s[3] ^ sum_s[3];
        last_s          = (idx_q == IDX_LAST);
        result_d        = result_q;
        result_d[nib_base_s +: 4] = sum_s[3:0];
    end

    // Control FSM plus operand, carry, result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= {IDXW{1'b0}};
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= {W{1'b0}};
            cout_q   <= 1'b0;
            v_q      <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        carry_q <= op;
                        idx_q   <= {IDXW{1'b0}};
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    result_q <= result_d;
                    carry_q  <= sum_s[4];
                    if (last_s) begin
                        idx_q   <= {IDXW{1'b0}};
                        cout_q  <= sum_s[4];
                        v_q     <= carry_into_b3_s ^ sum_s[4];
                        zero_q  <= (result_d == {W{1'b0}});
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Start is ignored here; the result is held until the next accepted start.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= {IDXW{1'b0}};
                end
            endcase
        end
    end

    // Handshake outputs are decoded directly from the state register, so they
    // stay glitch-free and mutually exclusive.
    assign ready  = (state_q == ST_IDLE);
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign v      = v_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Directed bench for serial_add_sub_ctrl (NIBBLES=4): table of add/sub vectors with
// hand-computed results, plus sequences for ignored starts and mid-run reset.
module tb_serial_add_sub_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        v;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;

    serial_add_sub_ctrl #(.NIBBLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .v      (v),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        cout;
        logic        v;
        logic        zero;
        logic        glitch;
        string       name;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called just after a negedge with the DUT in IDLE. Returns just after the
    // negedge following the DONE cycle, so back-to-back calls start every 6 cycles.
    task automatic run_op(input vec_t t);
        logic seen;
        int   n;
        chk({t.name, "_ready_pre"}, 32'(ready), 32'd1);
        start = 1'b1;
        op    = t.op;
        a     = t.a;
        b     = t.b;
        @(posedge clk);
        seen = 1'b0;
        n    = -1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            // Operands wiggled after acceptance must have no effect.
            start = 1'b0;
            op    = ~t.op;
            a     = ~t.a;
            b     = t.b ^ 16'h5A5A;
            if (done) begin
                seen = 1'b1;
                n    = i;
            end else begin
                if (i < 4) chk({t.name, "_busy"}, 32'(busy), 32'd1);
                if (t.glitch && i == 1) begin
                    start = 1'b1;
                    a     = 16'hDEAD;
                    b     = 16'hBEEF;
                end
            end
        end
        chk({t.name, "_done_seen"}, 32'(seen), 32'd1);
        chk({t.name, "_latency"}, 32'(n), 32'd4);
        chk({t.name, "_result"}, 32'(result), 32'(t.res));
        chk({t.name, "_cout"}, 32'(cout), 32'(t.cout));
        chk({t.name, "_v"}, 32'(v), 32'(t.v));
        chk({t.name, "_zero"}, 32'(zero), 32'(t.zero));
        chk({t.name, "_excl"}, 32'({ready, busy, done}), 32'(seen ? 3'b001 : 3'b000));
        if (t.glitch) begin
            start = 1'b1;
            op    = 1'b1;
            a     = 16'h0F0F;
            b     = 16'h7777;
        end
        @(negedge clk);
        start = 1'b0;
        chk({t.name, "_done_width"}, 32'(done), 32'd0);
        chk({t.name, "_ready_post"}, 32'(ready), 32'd1);
        chk({t.name, "_result_hold"}, 32'(result), 32'(t.res));
        chk({t.name, "_cout_hold"}, 32'(cout), 32'(t.cout));
    endtask

    initial begin
        vec_t t;
        logic done_after_rst;

        //          op    a         b         res       c     v     z     glitch name
        vecs[0] = '{1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0, 1'b0, "add_1234_0fcd"};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, "add_ripple"};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, "add_ovf"};
        vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, "sub_ovf"};
        vecs[4] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, "sub_borrow"};
        vecs[5] = '{1'b1, 16'h0007, 16'h0007, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, "sub_equal"};
        vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, "add_negovf"};
        vecs[7] = '{1'b1, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, "sub_min"};
        vecs[8] = '{1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b1, "ignored_start"};
        vecs[9] = '{1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, "add_after_ign"};

        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({cout, v, zero}), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back operations at the tightest legal spacing.
        for (int i = 0; i < 10; i++) begin
            t = vecs[i];
            run_op(t);
        end

        // Reset during the second RUN cycle aborts without a done pulse.
        start = 1'b1;
        op    = 1'b0;
        a     = 16'h1234;
        b     = 16'h0FCD;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy_clr", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_zero", 32'(zero), 32'd1);
        done_after_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) done_after_rst = 1'b1;
        end
        chk("abort_no_done", 32'(done_after_rst), 32'd0);

        t = '{1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, "add_post_rst"};
        run_op(t);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
